// File: rtl/cpu_pkg.sv
// Shared decode-side types: immediate-extension mode encodings and the
// state encoding of the immediate-extension unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IMM_ROT8   = 2'b00,
    IMM_ZEXT12 = 2'b01,
    IMM_SEXT12 = 2'b10,
    IMM_BR24   = 2'b11
  } imm_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } imm_state_e;

  localparam int unsigned IMM_W = 24;
  localparam int unsigned ROT_W = 4;

endpackage : cpu_pkg

// File: rtl/imm_ror_comb.sv
// Combinational DATA_W-bit rotate-right by an even amount (2 * rot4).
module imm_ror_comb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [ROT_W-1:0]  rot4,
  output logic [DATA_W-1:0] result
);

  logic [ROT_W:0] amt;

  // Shifting the doubled word right and keeping the low half is a rotate.
  assign amt    = {rot4, 1'b0};
  assign result = DATA_W'({data, data} >> amt);

endmodule : imm_ror_comb

// File: rtl/imm_extend_unit.sv
// Immediate-extension unit: turns the 24-bit instruction immediate into a
// DATA_W-bit operand with a registered valid/ready output stage.
module imm_extend_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter bit          ITERATIVE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              busy
);

  imm_state_e          state, state_next;
  logic [DATA_W-1:0]   work, work_next;
  logic [ROT_W-1:0]    count, count_next;
  logic [DATA_W-1:0]   out_imm_next;
  logic                out_valid_next;

  imm_mode_e           mode_e;
  logic [ROT_W-1:0]    rot_amt;
  logic [DATA_W-1:0]   zext8;
  logic [DATA_W-1:0]   rot8_res;
  logic [DATA_W-1:0]   step_out;
  logic [DATA_W-1:0]   single_res;
  logic                accept;
  logic                go_rot;

  assign mode_e  = imm_mode_e'(mode);
  assign rot_amt = imm_in[11:8];
  assign zext8   = {{(DATA_W-8){1'b0}}, imm_in[7:0]};

  generate
    if (ITERATIVE) begin : g_iter
      logic [DATA_W-1:0] step_in;

      // One rotator serves both the first step from IDLE and every ROT step.
      assign step_in  = (state == ROT) ? work : zext8;
      assign rot8_res = rot_amt[0] ? step_out : zext8;

      imm_ror_comb #(.DATA_W(DATA_W)) u_ror_step (
        .data   (step_in),
        .rot4   (4'd1),
        .result (step_out)
      );
    end else begin : g_barrel
      assign step_out = '0;

      imm_ror_comb #(.DATA_W(DATA_W)) u_ror_full (
        .data   (zext8),
        .rot4   (rot_amt),
        .result (rot8_res)
      );
    end
  endgenerate

  always_comb begin
    single_res = '0;
    unique case (mode_e)
      IMM_ROT8:   single_res = rot8_res;
      IMM_ZEXT12: single_res = {{(DATA_W-12){1'b0}}, imm_in[11:0]};
      IMM_SEXT12: single_res = {{(DATA_W-12){imm_in[11]}}, imm_in[11:0]};
      // imm_in[23] is reused as the top offset bit so the replication is never empty.
      IMM_BR24:   single_res = {{(DATA_W-25){imm_in[23]}}, imm_in[22:0], 2'b00};
      default:    single_res = '0;
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign go_rot   = ITERATIVE && (mode_e == IMM_ROT8) && (rot_amt >= 4'd2);
  assign busy     = (state == ROT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    work_next      = work;
    count_next     = count;
    out_imm_next   = out_imm;
    out_valid_next = out_valid;

    if (out_valid && out_ready) begin
      out_valid_next = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (go_rot) begin
            state_next = ROT;
            work_next  = step_out;
            count_next = rot_amt - 4'd1;
          end else begin
            out_imm_next   = single_res;
            out_valid_next = 1'b1;
          end
        end
      end
      ROT: begin
        work_next  = step_out;
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          out_imm_next   = step_out;
          out_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      out_imm   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      count     <= count_next;
      out_imm   <= out_imm_next;
      out_valid <= out_valid_next;
    end
  end

endmodule : imm_extend_unit
